// File: rtl/immediate_decoder_if.sv
// rtl/immediate_decoder_if.sv - instruction-in / decoded-fields-out handshake bundle
interface immediate_decoder_if;
    logic [15:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic        imm_sel;
    logic [15:0] immediate;
    logic        prefix_err;

    modport master (
        output instr, in_valid, out_ready,
        input  in_ready, out_valid, opcode, rd, rs, imm_sel, immediate, prefix_err
    );

    modport slave (
        input  instr, in_valid, out_ready,
        output in_ready, out_valid, opcode, rd, rs, imm_sel, immediate, prefix_err
    );
endinterface

// File: rtl/immediate_decoder.sv
// rtl/immediate_decoder.sv - decodes 16-bit instructions, merging an optional prefix word into a 16-bit immediate
module immediate_decoder #(
    parameter logic [3:0] EXT_OPCODE = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    immediate_decoder_if.slave bus
);
    localparam logic [0:0] IDLE        = 1'b0;
    localparam logic [0:0] HAVE_PREFIX = 1'b1;

    logic [0:0]  state;
    logic [7:0]  pfx_byte;
    logic        out_valid_q;
    logic [3:0]  opcode_q;
    logic [3:0]  rd_q;
    logic [3:0]  rs_q;
    logic        imm_sel_q;
    logic [15:0] immediate_q;
    logic        prefix_err_q;

    logic [3:0]  op;
    logic [7:0]  imm8;
    logic        is_prefix;
    logic        imm_form;
    logic        accept;
    logic [15:0] ext_imm;
    logic [15:0] imm_next;

    assign op        = bus.instr[15:12];
    assign imm8      = bus.instr[7:0];
    assign is_prefix = (op == EXT_OPCODE);
    assign imm_form  = op[3] && !is_prefix;

    // Single output register: input may be taken whenever that register drains this cycle.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign ext_imm  = op[2] ? {8'h00, imm8} : {{8{imm8[7]}}, imm8};
    assign imm_next = !imm_form ? 16'h0000 :
                      (state == HAVE_PREFIX) ? {pfx_byte, imm8} : ext_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pfx_byte     <= 8'h00;
            out_valid_q  <= 1'b0;
            opcode_q     <= 4'h0;
            rd_q         <= 4'h0;
            rs_q         <= 4'h0;
            imm_sel_q    <= 1'b0;
            immediate_q  <= 16'h0000;
            prefix_err_q <= 1'b0;
        end else begin
            prefix_err_q <= 1'b0;
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (is_prefix) begin
                    // A second prefix overwrites the first and flags the lost byte.
                    pfx_byte     <= imm8;
                    prefix_err_q <= (state == HAVE_PREFIX);
                    state        <= HAVE_PREFIX;
                end else begin
                    out_valid_q  <= 1'b1;
                    opcode_q     <= op;
                    rd_q         <= bus.instr[11:8];
                    rs_q         <= imm_form ? 4'h0 : bus.instr[3:0];
                    imm_sel_q    <= imm_form;
                    immediate_q  <= imm_next;
                    prefix_err_q <= (state == HAVE_PREFIX) && !imm_form;
                    state        <= IDLE;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.opcode     = opcode_q;
    assign bus.rd         = rd_q;
    assign bus.rs         = rs_q;
    assign bus.imm_sel    = imm_sel_q;
    assign bus.immediate  = immediate_q;
    assign bus.prefix_err = prefix_err_q;
endmodule

// File: tb/tb_immediate_decoder.sv
// tb/tb_immediate_decoder.sv - directed and randomized checks of immediate_decoder against a reference model
module tb_immediate_decoder;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    immediate_decoder_if bus ();

    immediate_decoder #(.EXT_OPCODE(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected contents of the output stage plus pending prefix.
    logic        m_valid;
    logic [3:0]  m_op, m_rd, m_rs;
    logic        m_sel;
    logic [15:0] m_imm;
    logic        m_err;
    logic        m_have;
    int          m_pfx;

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_rd = 0; m_rs = 0; m_sel = 0;
        m_imm = 0; m_err = 0; m_have = 0; m_pfx = 0;
    endtask

    task automatic model_clock(input logic [15:0] w, input logic v, input logic r);
        int  op, imm8;
        bit  acc;
        acc   = v && (!m_valid || r);
        op    = w / 4096;
        imm8  = w % 256;
        m_err = 0;
        if (m_valid && r) m_valid = 0;
        if (acc) begin
            if (op == 15) begin
                if (m_have) m_err = 1;
                m_have = 1;
                m_pfx  = imm8;
            end else begin
                m_valid = 1;
                m_op    = op[3:0];
                m_rd    = 4'((w / 256) % 16);
                if (op >= 8) begin
                    m_sel = 1;
                    m_rs  = 0;
                    if (m_have)             m_imm = 16'(m_pfx * 256 + imm8);
                    else if ((op / 4) % 2)  m_imm = 16'(imm8);
                    else if (imm8 >= 128)   m_imm = 16'(imm8 + 65280);
                    else                    m_imm = 16'(imm8);
                end else begin
                    m_sel = 0;
                    m_rs  = 4'(w % 16);
                    m_imm = 0;
                    if (m_have) m_err = 1;
                end
                m_have = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 16'(bus.in_ready), 16'(!m_valid || bus.out_ready));
        chk("out_valid", 16'(bus.out_valid), 16'(m_valid));
        chk("prefix_err", 16'(bus.prefix_err), 16'(m_err));
        if (m_valid) begin
            chk("opcode", 16'(bus.opcode), 16'(m_op));
            chk("rd", 16'(bus.rd), 16'(m_rd));
            chk("rs", 16'(bus.rs), 16'(m_rs));
            chk("imm_sel", 16'(bus.imm_sel), 16'(m_sel));
            chk("immediate", bus.immediate, m_imm);
        end
    endtask

    task automatic step(input logic [15:0] w, input logic v, input logic r);
        bus.instr = w; bus.in_valid = v; bus.out_ready = r;
        #1;
        check_model();
        model_clock(w, v, r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 16'(bus.out_valid), 16'h0);
        chk({tag, "_err"}, 16'(bus.prefix_err), 16'h0);
        chk({tag, "_fields"}, {bus.opcode, bus.rd, bus.rs, 3'b000, bus.imm_sel}, 16'h0);
        chk({tag, "_imm"}, bus.immediate, 16'h0);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        bus.instr = 16'h0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 16'(bus.in_ready), 16'h1);

        // Register form
        step(16'h0A03, 1, 1);
        chk("r034_valid", 16'(bus.out_valid), 16'h1);
        chk("r034_fields", {bus.opcode, bus.rd, bus.rs, 3'b000, bus.imm_sel}, 16'h0A30);
        chk("r034_imm", bus.immediate, 16'h0000);

        // Sign / zero extension
        step(16'h92F0, 1, 1);
        chk("sext_imm", bus.immediate, 16'hFFF0);
        chk("sext_sel", 16'(bus.imm_sel), 16'h1);
        step(16'hD2F0, 1, 1);
        chk("zext_imm", bus.immediate, 16'h00F0);

        // Prefix merge
        step(16'hF012, 1, 1);
        step(16'h9534, 1, 1);
        chk("pfx_imm", bus.immediate, 16'h1234);
        chk("pfx_rd", 16'(bus.rd), 16'h5);
        step(16'h0000, 0, 1);

        // Prefix followed by register form
        step(16'hF0AA, 1, 1);
        step(16'h0103, 1, 1);
        chk("perr_rs", 16'(bus.rs), 16'h3);
        chk("perr_pulse", 16'(bus.prefix_err), 16'h1);
        step(16'h0000, 0, 1);

        // Double prefix
        step(16'hF011, 1, 1);
        step(16'hF022, 1, 1);
        chk("dbl_pulse", 16'(bus.prefix_err), 16'h1);
        step(16'h9033, 1, 1);
        chk("dbl_imm", bus.immediate, 16'h2233);
        chk("dbl_err_clear", 16'(bus.prefix_err), 16'h0);

        // Backpressure
        step(16'h0A03, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(16'h9111, 1, 0);
            chk("bp_hold_rd", 16'(bus.rd), 16'hA);
            chk("bp_hold_ready", 16'(bus.in_ready), 16'h0);
        end
        step(16'h9111, 1, 1);
        chk("bp_next_imm", bus.immediate, 16'h0011);
        step(16'hD222, 1, 1);
        chk("bp_b2b_imm", bus.immediate, 16'h0022);
        step(16'h1333, 1, 1);
        chk("bp_b2b_rs", 16'(bus.rs), 16'h3);
        step(16'h0000, 0, 1);

        // Asynchronous reset between prefix and its consumer
        step(16'hF012, 1, 1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        #1;
        reset = 1'b0;
        #1;
        chk("ready_after_areset", 16'(bus.in_ready), 16'h1);
        @(posedge clk); #1;
        step(16'h9534, 1, 1);
        chk("post_reset_imm", bus.immediate, 16'h0034);
        step(16'h0000, 0, 1);

        // Randomized traffic, biased toward prefix words
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
            step(w, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        step(16'h0000, 0, 1);
        step(16'h0000, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
